viterbi_frame_ctrl: RTL and testbench
=====================================

Name: viterbi_frame_ctrl

Overview:
Frame sequencer for the Viterbi decoder front end. It accepts 2-bit received symbols over a valid/ready handshake and forwards them into the 2-bit symbol pipe stage with a registered enable. After FRAME_LEN symbols it injects TAIL_LEN zero tail symbols, then triggers traceback and waits for completion or timeout. It sits between the symbol source and the pipe/ACS/traceback datapath and owns per-frame step indexing.

Parameters:
FRAME_LEN, 32, data symbols per frame (>=1)
TAIL_LEN, 2, zero flush symbols appended (K-1; >=0)
TB_TIMEOUT, 64, max cycles in TRACE waiting for tb_done (>=1)
CNT_W, 8, width of step_idx/counters; 2^CNT_W > FRAME_LEN+TAIL_LEN and > TB_TIMEOUT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a frame; sampled only in IDLE
sym_in  in  2  received symbol
sym_valid  in  1  sym_in valid
sym_ready  out  1  controller accepts symbol this cycle
pipe_in  out  2  symbol to pipe stage (registered)
pipe_en  out  1  pipe_in valid, 1-cycle strobe per symbol (registered)
frame_first  out  1  high with pipe_en for step 0 only (metric init)
step_idx  out  CNT_W  trellis step of current pipe_in, 0..FRAME_LEN+TAIL_LEN-1
tb_start  out  1  1-cycle traceback trigger
tb_done  in  1  traceback complete
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse, frame finished OK
err  out  1  1-cycle pulse, traceback timeout

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; counters 0. Reset mid-frame discards the frame, no done/err.
- States: IDLE, LOAD, FLUSH, TRACE, DONE.
- IDLE: sym_ready=0. start=1 -> LOAD next cycle; counter cleared.
- LOAD: sym_ready=1 (combinational from state). Handshake = sym_valid & sym_ready. On handshake: next cycle pipe_in=sym_in, pipe_en=1, step_idx=count, frame_first=(count==0); count++. No handshake -> pipe_en=0, pipe_in/step_idx hold. On the FRAME_LEN-th handshake -> FLUSH (TAIL_LEN=0 -> TRACE).
- Latency: handshake to pipe_en exactly 1 cycle; back-to-back symbols give consecutive pipe_en strobes.
- FLUSH: sym_ready=0; each cycle emit pipe_in=0, pipe_en=1, step_idx=count, count++; after TAIL_LEN cycles -> TRACE. Tail strobes contiguous with last data strobe when that data was accepted in the final LOAD cycle.
- TRACE: tb_start=1 on first cycle only; timeout counter starts at 0. tb_done=1 -> DONE. Counter reaches TB_TIMEOUT-1 without tb_done -> err pulse, -> IDLE. tb_done and timeout in same cycle: tb_done wins (DONE, no err). tb_done outside TRACE ignored.
- DONE: done=1 for one cycle, -> IDLE. start in DONE ignored; earliest new frame start is the following IDLE cycle.
- start outside IDLE ignored; sym_valid outside LOAD ignored (sym_ready=0).
- Counters wrap-free by parameter constraint; step_idx never exceeds FRAME_LEN+TAIL_LEN-1.

Test Plan:
- FRAME_LEN=4, TAIL_LEN=2: start, then symbols 1,0,2,3 with sym_valid held -> pipe_en 6 consecutive cycles, pipe_in 1,0,2,3,0,0, step_idx 0..5, frame_first only at step 0, one tb_start pulse; tb_done 3 cycles later -> done pulse, busy falls next cycle.
- Gapped input: sym_valid toggling 1,0,1,0 with symbols 3,1 -> pipe_en only 1 cycle after each handshake, step_idx 0 then 1, pipe_in holds 3 between strobes.
- Timeout, TB_TIMEOUT=8, tb_done never asserted -> err pulse exactly 8 cycles after tb_start, state IDLE, done never asserted.
- tb_done asserted in the same cycle timeout expires -> done=1, err=0.
- reset driven low mid-LOAD after 2 of 4 symbols -> all outputs 0 immediately (asynchronously); after release a new start runs a full frame with step_idx restarting at 0.
- start held high through DONE and sym_valid high in IDLE -> no symbol accepted before LOAD; new frame begins only from IDLE.

Source files
------------

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the Viterbi front end: accepts FRAME_LEN symbols, appends
// TAIL_LEN zero flush symbols, then triggers traceback and waits for completion.
module viterbi_frame_ctrl #(
  parameter int unsigned FRAME_LEN  = 32,
  parameter int unsigned TAIL_LEN   = 2,
  parameter int unsigned TB_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic [1:0]       pipe_in,
  output logic             pipe_en,
  output logic             frame_first,
  output logic [CNT_W-1:0] step_idx,
  output logic             tb_start,
  input  logic             tb_done,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_TRACE,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(FRAME_LEN + TAIL_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TB_TIMEOUT - 1);
  localparam bit               NO_TAIL   = (TAIL_LEN == 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_tcnt;
  logic [1:0]       r_pipe_in;
  logic             r_pipe_en;
  logic             r_first;
  logic [CNT_W-1:0] r_step;
  logic             r_tb_start;
  logic             r_done;
  logic             r_err;
  logic             w_hs;

  assign sym_ready   = (r_state == S_LOAD);
  assign busy        = (r_state != S_IDLE);
  assign w_hs        = sym_valid && (r_state == S_LOAD);
  assign pipe_in     = r_pipe_in;
  assign pipe_en     = r_pipe_en;
  assign frame_first = r_first;
  assign step_idx    = r_step;
  assign tb_start    = r_tb_start;
  assign done        = r_done;
  assign err         = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_tcnt     <= '0;
      r_pipe_in  <= '0;
      r_pipe_en  <= 1'b0;
      r_first    <= 1'b0;
      r_step     <= '0;
      r_tb_start <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_pipe_en  <= 1'b0;
      r_first    <= 1'b0;
      r_tb_start <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_hs) begin
            r_pipe_in <= sym_in;
            r_pipe_en <= 1'b1;
            r_step    <= r_cnt;
            r_first   <= (r_cnt == '0);
            r_cnt     <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_DATA) begin
              if (NO_TAIL) begin
                r_state    <= S_TRACE;
                r_tb_start <= 1'b1;
                r_tcnt     <= '0;
              end else begin
                r_state <= S_FLUSH;
              end
            end
          end
        end
        S_FLUSH: begin
          r_pipe_in <= '0;
          r_pipe_en <= 1'b1;
          r_step    <= r_cnt;
          r_cnt     <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_STEP) begin
            r_state    <= S_TRACE;
            r_tb_start <= 1'b1;
            r_tcnt     <= '0;
          end
        end
        S_TRACE: begin
          // tb_done takes priority over a timeout expiring in the same cycle
          if (tb_done) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (r_tcnt == LAST_WAIT) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + CNT_W'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Scoreboard bench for viterbi_frame_ctrl: the driver predicts each frame's
// strobes and end event from the frame rules; a negedge monitor checks them.
module tb_viterbi_frame_ctrl;

  localparam int FL = 4;
  localparam int TL = 2;
  localparam int TO = 8;
  localparam int CW = 8;
  localparam int NS = FL + TL;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    sym_in = '0;
  logic          sym_valid = 1'b0;
  logic          tb_done = 1'b0;
  logic          sym_ready;
  logic [1:0]    pipe_in;
  logic          pipe_en;
  logic          frame_first;
  logic [CW-1:0] step_idx;
  logic          tb_start;
  logic          busy;
  logic          done;
  logic          err;

  viterbi_frame_ctrl #(
    .FRAME_LEN (FL),
    .TAIL_LEN  (TL),
    .TB_TIMEOUT(TO),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .pipe_in    (pipe_in),
    .pipe_en    (pipe_en),
    .frame_first(frame_first),
    .step_idx   (step_idx),
    .tb_start   (tb_start),
    .tb_done    (tb_done),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       cyc;
    logic [1:0] sym;
    int       step;
  } strobe_t;

  typedef struct {
    int cyc;
    bit is_err;
  } ev_t;

  strobe_t    sq[$];
  ev_t        eq[$];
  int         checks = 0;
  int         failures = 0;
  logic [1:0] syms[FL];
  logic [1:0] last_sym = '0;
  logic [7:0] last_step = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin : monitor
    strobe_t s;
    ev_t     e;
    if (!reset) begin
      last_sym  = '0;
      last_step = '0;
    end else begin
      if (pipe_en) begin
        if (sq.size() == 0) begin
          chk("unexpected_strobe", 32'(step_idx), 32'hFFFF);
        end else begin
          s = sq.pop_front();
          chk("strobe_cycle", cyc, s.cyc);
          chk("strobe_fields", {pipe_in, step_idx, frame_first, tb_start},
              {s.sym, 8'(s.step), (s.step == 0), (s.step == NS - 1)});
          last_sym  = s.sym;
          last_step = 8'(s.step);
        end
      end else begin
        chk("hold_idle_strobe", {pipe_in, step_idx, frame_first, tb_start},
            {last_sym, last_step, 2'b00});
      end
      if (done || err) begin
        if (eq.size() == 0) begin
          chk("unexpected_end", {done, err}, 2'b00);
        end else begin
          e = eq.pop_front();
          chk("end_cycle", cyc, e.cyc);
          chk("end_kind", {done, err}, e.is_err ? 2'b01 : 2'b10);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(string name);
    chk(name, {sym_ready, pipe_in, pipe_en, frame_first, step_idx, tb_start, busy, done, err}, '0);
  endtask

  // d < 0: traceback never completes; otherwise tb_done is seen d cycles after tb_start
  task automatic do_frame(input bit gap, input int d, input bit keep_start);
    int last_cyc;
    int ts;
    start = 1'b1;
    step();
    if (!keep_start) start = 1'b0;
    for (int i = 0; i < FL; i++) begin
      chk("sym_ready_load", sym_ready, 1);
      sym_valid = 1'b1;
      sym_in    = syms[i];
      sq.push_back('{cyc + 1, syms[i], i});
      last_cyc = cyc + 1;
      step();
      if (gap && i < FL - 1) begin
        sym_valid = 1'b0;
        sym_in    = 2'($urandom);
        chk("sym_ready_gap", sym_ready, 1);
        step();
      end
    end
    sym_valid = 1'($urandom);
    sym_in    = 2'($urandom);
    for (int t = 0; t < TL; t++) sq.push_back('{last_cyc + 1 + t, 2'b00, FL + t});
    ts = last_cyc + TL;
    chk("sym_ready_after_load", sym_ready, 0);
    while (cyc < ts) step();
    if (d >= 0) begin
      repeat (d) step();
      tb_done = 1'b1;
      eq.push_back('{ts + d + 1, 1'b0});
      step();
      tb_done = 1'b0;
      chk("busy_in_done", busy, 1);
      step();
      chk("busy_after_done", busy, 0);
    end else begin
      eq.push_back('{ts + TO, 1'b1});
      while (cyc < ts + TO) step();
      chk("busy_after_err", busy, 0);
    end
  endtask

  task automatic rand_syms();
    for (int i = 0; i < FL; i++) syms[i] = 2'($urandom);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int d;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_outputs");
    reset = 1'b1;
    step();
    chk_all_zero("idle_after_release");

    syms = '{2'd1, 2'd0, 2'd2, 2'd3};
    do_frame(1'b0, 3, 1'b0);

    rand_syms();
    syms[0] = 2'd3;
    syms[1] = 2'd1;
    do_frame(1'b1, 2, 1'b0);

    rand_syms();
    do_frame(1'b0, -1, 1'b0);

    rand_syms();
    do_frame(1'b0, TO - 1, 1'b0);

    // reset in the middle of LOAD after two accepted symbols
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sym_valid = 1'b1;
      sym_in    = 2'(i + 2);
      sq.push_back('{cyc + 1, 2'(i + 2), i});
      step();
    end
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset_mid_load");
    sym_valid = 1'b0;
    sq.delete();
    eq.delete();
    step();
    step();
    reset = 1'b1;
    step();
    chk_all_zero("idle_after_mid_reset");
    rand_syms();
    do_frame(1'b0, 1, 1'b0);

    // start held through DONE, sym_valid high in IDLE
    rand_syms();
    do_frame(1'b1, 4, 1'b1);
    sym_valid = 1'b1;
    sym_in    = 2'd2;
    chk("sym_ready_idle", sym_ready, 0);
    rand_syms();
    do_frame(1'b0, 0, 1'b1);
    start = 1'b0;

    for (int n = 0; n < 10; n++) begin
      rand_syms();
      d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      do_frame(1'($urandom), d, 1'b0);
      repeat ($urandom_range(0, 2)) step();
    end

    sym_valid = 1'b0;
    repeat (3) step();
    chk("strobes_drained", sq.size(), 0);
    chk("events_drained", eq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
